// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - eight-phase instruction sequencer for the 8-bit accumulator processor
// Generates fetch/execute strobes from a free-running phase counter and a sticky halt flag.
module phase_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ldir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic [2:0] phase_q;
  logic       halted_q;
  logic       is_hlt;
  logic       is_skz;
  logic       is_sto;
  logic       is_jmp;
  logic       aluop;
  logic       enter_halt;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  // Halt is taken on the edge that ends OP_ADDR; the counter then stays parked at 4.
  assign enter_halt = !halted_q && (phase_q == PH_OP_ADDR) && is_hlt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else if (enter_halt) begin
      halted_q <= 1'b1;
    end else if (!halted_q) begin
      phase_q <= phase_q + 3'd1;
    end
  end

  assign phase = phase_q;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ldir   = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel  = 1'b1;
          rd   = 1'b1;
          ldir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        PH_OP_FETCH: begin
          rd = aluop;
        end
        PH_ALU_OP: begin
          rd     = aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          // inc_pc with ld_pc on JMP is harmless: the PC gives load priority.
          rd     = aluop;
          ld_ac  = aluop;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ldir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  phase_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ldir(ldir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_phase = 0;
  bit m_halted = 1'b0;

  wire [11:0] obs = {phase, sel, rd, ldir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [7:0] sel_m, rd_m, ldir_m, inc_m, ldpc_m, ldac_m, wr_m, de_m;
  } instr_vec_t;

  instr_vec_t vecs[$];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d outs=%b, expected phase=%0d outs=%b",
               name, act[11:9], act[8:0], exp[11:9], exp[8:0]);
    end
  endtask

  // Reference: expected strobes from the phase rules, expressed as phase ranges.
  function automatic logic [11:0] model_out(int ph, bit hl, logic [2:0] op, logic z);
    bit alu, s, r, l, ip, lp, la, w, de, h;
    if (hl) return {3'd4, 9'b0_0000_0001};
    alu = (op >= 3'd2) && (op <= 3'd5);
    s   = (ph <= 3);
    r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    l   = (ph == 2) || (ph == 3);
    ip  = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    lp  = (ph >= 6) && (op == 3'd7);
    la  = (ph == 7) && alu;
    w   = (ph == 7) && (op == 3'd6);
    de  = (ph >= 6) && (op == 3'd6);
    h   = (ph == 4) && (op == 3'd0);
    return {3'(ph), s, r, l, ip, lp, la, w, de, h};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_phase  = 0;
    m_halted = 1'b0;
    check("reset_state", obs, {3'd0, 9'b1_0000_0000});
    #1;
    rst = 1'b1;
  endtask

  initial begin
    vecs.push_back('{3'd5, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00}); // LDA
    vecs.push_back('{3'd1, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00}); // SKZ taken
    vecs.push_back('{3'd1, 1'b0, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}); // SKZ not taken
    vecs.push_back('{3'd7, 1'b0, 8'h0F, 8'h0E, 8'h0C, 8'h90, 8'hC0, 8'h00, 8'h00, 8'h00}); // JMP
    vecs.push_back('{3'd6, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h80, 8'hC0}); // STO
    vecs.push_back('{3'd2, 1'b1, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00}); // ADD
    vecs.push_back('{3'd4, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00}); // XOR

    @(posedge clk);
    #2;
    do_reset();

    // Table-driven instruction sequences, back to back from phase 0.
    foreach (vecs[k]) begin
      for (int ph = 0; ph < 8; ph++) begin
        opcode = vecs[k].op;
        zero   = vecs[k].z;
        #1;
        check($sformatf("table_op%0d_z%0d_ph%0d", vecs[k].op, vecs[k].z, ph), obs,
              {3'(ph), vecs[k].sel_m[ph], vecs[k].rd_m[ph], vecs[k].ldir_m[ph],
               vecs[k].inc_m[ph], vecs[k].ldpc_m[ph], vecs[k].ldac_m[ph],
               vecs[k].wr_m[ph], vecs[k].de_m[ph], 1'b0});
        step();
      end
    end

    // Asynchronous reset mid-instruction at phase 5, then a clean phase run.
    do_reset();
    opcode = 3'd5;
    for (int i = 0; i < 5; i++) step();
    check("reach_phase5", {phase, 9'b0}, {3'd5, 9'b0});
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("post_reset_phase%0d", i % 8), {phase, 9'b0}, {3'(i % 8), 9'b0});
    end

    // HLT: enters halt at phase 4, then freezes regardless of inputs.
    do_reset();
    opcode = 3'd0;
    for (int i = 0; i < 4; i++) step();
    #1;
    check("hlt_phase4", obs, {3'd4, 9'b0_0010_0001});
    for (int i = 0; i < 20; i++) begin
      step();
      opcode = 3'($urandom);
      zero   = 1'($urandom);
    end
    #1;
    check("hlt_frozen", obs, {3'd4, 9'b0_0000_0001});
    do_reset();
    step();
    check("hlt_restart_phase1", {phase, halt, 8'b0}, {3'd1, 1'b0, 8'b0});

    // Randomized stimulus against the reference model.
    do_reset();
    begin
      int halted_cycles = 0;
      for (int c = 0; c < 3000; c++) begin
        opcode = 3'($urandom);
        zero   = 1'($urandom);
        #1;
        check($sformatf("rand_c%0d", c), obs, model_out(m_phase, m_halted, opcode, zero));
        if (m_halted) halted_cycles++;
        step();
        if ($urandom_range(0, 99) == 0 || halted_cycles > 12) begin
          halted_cycles = 0;
          do_reset();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Eight-phase instruction sequencer (control unit) for the 8-bit accumulator processor. It sits directly downstream of the instruction register: it consumes the 3-bit opcode that the instruction register latches, drives that register's `ldir` load strobe, and generates all datapath strobes for memory, PC, accumulator and bus. Each instruction takes exactly eight clock cycles unless the processor halts.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `opcode`  input  3  instruction-register opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero`  input  1  accumulator-zero flag from the ALU.
- `sel`  output  1  address mux: 1 selects PC, 0 selects IR address field.
- `rd`  output  1  memory read enable.
- `ldir`  output  1  instruction-register load strobe.
- `inc_pc`  output  1  PC increment.
- `ld_pc`  output  1  PC parallel load from the IR address field.
- `ld_ac`  output  1  accumulator load from the ALU.
- `wr`  output  1  memory write strobe.
- `data_e`  output  1  accumulator-to-data-bus driver enable.
- `halt`  output  1  processor halted.
- `phase`  output  3  current phase number (debug/verification).

## Operation
- State: 3-bit phase counter, plus a sticky `halted` flag.
- Phase counter advances 0→1→…→7→0, one step per clock. It wraps 7→0 with no idle cycle.
- ALUOP means opcode ∈ {ADD, AND, XOR, LDA}.
- Outputs are combinational decode of `phase`, `opcode`, `zero` and `halted`. Any signal not listed for a phase is 0.
  - 0 INST_ADDR: `sel`.
  - 1 INST_FETCH: `sel`, `rd`.
  - 2 INST_LOAD: `sel`, `rd`, `ldir`.
  - 3 IDLE: `sel`, `rd`, `ldir`.
  - 4 OP_ADDR: `inc_pc`; `halt` = (opcode==HLT).
  - 5 OP_FETCH: `rd` = ALUOP.
  - 6 ALU_OP: `rd` = ALUOP; `inc_pc` = (opcode==SKZ && zero); `ld_pc` = (opcode==JMP); `data_e` = (opcode==STO).
  - 7 STORE: `rd` = ALUOP; `ld_ac` = ALUOP; `inc_pc` = (opcode==JMP); `ld_pc` = (opcode==JMP); `wr` = (opcode==STO); `data_e` = (opcode==STO).
- Halt entry:
  - At the clock edge that ends phase 4 with opcode==HLT, `halted` sets.
  - The counter freezes and reports `phase`=4.
- Halted behaviour:
  - `halt`=1; every other output is 0, including `inc_pc`.
  - The only exit is reset.
- `zero` is sampled only during phase 6. `opcode` is ignored in phases 0–3.

## Timing
- Reset (asserted asynchronously, any cycle): `phase`=0 and `halted`=0 immediately.
  - Outputs during and just after reset: `sel`=1, all others 0.
- The first rising edge after `rst` deasserts moves to phase 1.
- The instruction register captures on the edges that end phases 2 and 3, so `opcode` is valid from phase 3 onward.
- PC increments on the edge ending phase 4. It increments again on the edge ending phase 6 when a skip is taken.
- JMP: `ld_pc` high in phases 6 and 7. `inc_pc` in phase 7 is overridden by `ld_pc` in the PC (load has priority).
- STO: `data_e` high in phases 6–7; `wr` only in phase 7.
- Latency: 8 cycles per instruction. HLT takes 5 cycles (phases 0–4) to reach the halted state.
- Reset mid-instruction: the sequence aborts immediately, and the next fetch starts at phase 0.

## Test plan
- Reset with `rst`=0 held at phase 5: `phase`=0 and `sel`=1 with no clock edge. After release, phases run 1,2,…,7,0 on successive edges.
- opcode=LDA (5), zero=0: `rd`=1 in phases 1,2,3,5,6,7; `ldir`=1 in phases 2,3 only; `ld_ac`=1 only in phase 7; `inc_pc`=1 only in phase 4.
- opcode=SKZ (1), with zero=1 then zero=0 on the next instruction: `inc_pc` in phase 6 is 1 then 0; `ld_ac`, `wr`, `ld_pc` stay 0 throughout.
- opcode=JMP (7): `ld_pc`=1 in phases 6 and 7; `inc_pc`=1 in phases 4 and 7; `rd`=0 in phases 5–7.
- opcode=STO (6): `data_e`=1 in phases 6,7; `wr`=1 only in phase 7; `rd`=0 in phases 5–7.
- opcode=HLT (0): `halt`=1 from phase 4. After 20 further edges, `phase`=4, `halt`=1 and all other outputs 0. Asserting `rst` clears `halt` and restarts at phase 0.
